// File: rtl/dc_line_fetch_scheduler.sv
// Line fetch scheduler for the display controller: prefetches source lines into the
// line ring, retires old lines and acknowledges IPU window requests. Optional macro DC_LFS_STALL_COUNTER_EN.
module dc_line_fetch_scheduler #(
  parameter int LINE_NUMBER_WIDTH = 12,
  parameter int AXI_ARADDR_WIDTH  = 32,
  parameter int BUFFER_NUM        = 5,
  parameter int WINDOW_LINES      = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         frame_start,
  input  logic [AXI_ARADDR_WIDTH-1:0]  cfg_frame_addr,
  input  logic [AXI_ARADDR_WIDTH-1:0]  cfg_line_stride,
  input  logic [LINE_NUMBER_WIDTH-1:0] cfg_image_height,
  input  logic                         tex_request_valid,
  output logic                         tex_request_ready,
  input  logic [LINE_NUMBER_WIDTH-1:0] tex_request_y,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [LINE_NUMBER_WIDTH-1:0] fetch_line_number,
  output logic [AXI_ARADDR_WIDTH-1:0]  fetch_line_addr,
  input  logic                         fetch_done,
  output logic                         bu_next_line,
  output logic                         bu_flush,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         seq_err,
  output logic [15:0]                  stall_cycles
);

  localparam int LW    = LINE_NUMBER_WIDTH;
  localparam int AW    = AXI_ARADDR_WIDTH;
  localparam int RES_W = $clog2(BUFFER_NUM + 1);
  localparam logic [LW-1:0]    WIN     = LW'(WINDOW_LINES);
  localparam logic [RES_W-1:0] RES_MAX = RES_W'(BUFFER_NUM);

  typedef enum logic [1:0] {IDLE, ACTIVE, FETCH_REQ, FETCH_WAIT} state_t;

  state_t           state, state_d;
  logic [LW-1:0]    base, base_d;
  logic [LW-1:0]    next_fetch, next_fetch_d;
  logic [LW-1:0]    height, height_d;
  logic [RES_W-1:0] resident, resident_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    stride, stride_d;
  logic             seq_err_d;

  logic [LW-1:0]    remaining;
  logic [LW-1:0]    need;
  logic             served;

  // Window is clamped at the bottom of the image so the last rows need fewer lines.
  always_comb begin
    remaining = height - tex_request_y;
    need      = (remaining > WIN) ? WIN : remaining;
    served    = (tex_request_y == base) && (LW'(resident) >= need);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      base       <= '0;
      next_fetch <= '0;
      height     <= '0;
      resident   <= '0;
      addr_q     <= '0;
      stride     <= '0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_d;
      base       <= base_d;
      next_fetch <= next_fetch_d;
      height     <= height_d;
      resident   <= resident_d;
      addr_q     <= addr_d;
      stride     <= stride_d;
      seq_err    <= seq_err_d;
    end
  end

  always_comb begin
    state_d           = state;
    base_d            = base;
    next_fetch_d      = next_fetch;
    height_d          = height;
    resident_d        = resident;
    addr_d            = addr_q;
    stride_d          = stride;
    seq_err_d         = seq_err;
    tex_request_ready = 1'b0;
    bu_next_line      = 1'b0;
    bu_flush          = 1'b0;
    frame_done        = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state_d      = ACTIVE;
            base_d       = '0;
            next_fetch_d = '0;
            resident_d   = '0;
            addr_d       = cfg_frame_addr;
            stride_d     = cfg_line_stride;
            height_d     = cfg_image_height;
            seq_err_d    = 1'b0;
          end
        end
        ACTIVE: begin
          if (tex_request_valid && (tex_request_y < base)) begin
            tex_request_ready = 1'b1;
            seq_err_d         = 1'b1;
          end else if (tex_request_valid && (tex_request_y > base) && (resident != '0)) begin
            bu_next_line = 1'b1;
            base_d       = base + LW'(1);
            resident_d   = resident - RES_W'(1);
          end else if (tex_request_valid && served) begin
            tex_request_ready = 1'b1;
            if (tex_request_y == (height - LW'(1))) begin
              frame_done = 1'b1;
              bu_flush   = 1'b1;
              state_d    = IDLE;
            end
          end else if ((next_fetch < height) && (resident < RES_MAX)) begin
            state_d = FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (fetch_ready) state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (fetch_done) begin
            resident_d   = resident + RES_W'(1);
            next_fetch_d = next_fetch + LW'(1);
            addr_d       = addr_q + stride;
            state_d      = ACTIVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fetch_valid       = (state == FETCH_REQ);
  assign fetch_line_number = next_fetch;
  assign fetch_line_addr   = addr_q;
  assign busy              = (state != IDLE);

`ifdef DC_LFS_STALL_COUNTER_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= '0;
    end else if (en) begin
      if ((state == IDLE) && frame_start) begin
        stall_q <= '0;
      end else if (tex_request_valid && !tex_request_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dc_line_fetch_scheduler.sv
// Self-checking bench for dc_line_fetch_scheduler: cycle table for a tiny frame, then
// multi-cycle sequences for prefetch, advance, bottom clamp, backward requests, reset/en and stall count.
module tb_dc_line_fetch_scheduler;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic        frame_start = 1'b0;
  logic [31:0] cfg_frame_addr = '0;
  logic [31:0] cfg_line_stride = '0;
  logic [11:0] cfg_image_height = '0;
  logic        tex_request_valid = 1'b0;
  logic        tex_request_ready;
  logic [11:0] tex_request_y = '0;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [11:0] fetch_line_number;
  logic [31:0] fetch_line_addr;
  logic        fetch_done;
  logic        bu_next_line, bu_flush, frame_done, busy, seq_err;
  logic [15:0] stall_cycles;

  logic auto_fu = 1'b0;
  logic t_ready = 1'b0;
  logic t_done = 1'b0;
  logic a_done = 1'b0;
  int   done_delay = 3;

  assign fetch_ready = auto_fu ? 1'b1 : t_ready;
  assign fetch_done  = auto_fu ? a_done : t_done;

  dc_line_fetch_scheduler dut (
    .clk(clk), .nrst(nrst), .en(en), .frame_start(frame_start),
    .cfg_frame_addr(cfg_frame_addr), .cfg_line_stride(cfg_line_stride),
    .cfg_image_height(cfg_image_height),
    .tex_request_valid(tex_request_valid), .tex_request_ready(tex_request_ready),
    .tex_request_y(tex_request_y),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_line_number(fetch_line_number), .fetch_line_addr(fetch_line_addr),
    .fetch_done(fetch_done), .bu_next_line(bu_next_line), .bu_flush(bu_flush),
    .frame_done(frame_done), .busy(busy), .seq_err(seq_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          acc_cnt = 0;
  int          ready_cnt = 0;
  int          nl_cnt = 0;
  logic [11:0] acc_line [64];
  logic [31:0] acc_addr [64];

  // Everything is sampled on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (nrst) begin
      if (fetch_valid && fetch_ready && en) begin
        acc_line[acc_cnt % 64] = fetch_line_number;
        acc_addr[acc_cnt % 64] = fetch_line_addr;
        acc_cnt++;
      end
      if (tex_request_ready) ready_cnt++;
      if (bu_next_line) nl_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_fu && fetch_valid && en && nrst) begin
        @(posedge clk);
        repeat (done_delay - 1) @(posedge clk);
        #1 a_done = 1'b1;
        @(posedge clk);
        #1 a_done = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [11:0] h, input logic [31:0] a, input logic [31:0] s);
    cfg_image_height = h;
    cfg_frame_addr   = a;
    cfg_line_stride  = s;
    frame_start      = 1'b1;
    tick();
    frame_start      = 1'b0;
  endtask

  task automatic request(input logic [11:0] y, input int limit, output int waits,
                         output logic got_fd, output logic got_fl);
    logic seen;
    seen   = 1'b0;
    waits  = 0;
    got_fd = 1'b0;
    got_fl = 1'b0;
    tex_request_valid = 1'b1;
    tex_request_y     = y;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (tex_request_ready) begin
        seen   = 1'b1;
        got_fd = frame_done;
        got_fl = bu_flush;
      end else begin
        waits++;
      end
      tick();
    end
    tex_request_valid = 1'b0;
    check($sformatf("req_ack_y%0d", y), {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic        en, fs, rv;
    logic [11:0] ry;
    logic        fr, fd;
    logic [6:0]  ctl;   // {ready, next_line, flush, frame_done, fetch_valid, busy, seq_err}
    logic [11:0] line;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t v(input logic e, input logic fs, input logic rv, input logic [11:0] ry,
                             input logic fr, input logic fd, input logic [6:0] ctl,
                             input logic [11:0] line, input logic [31:0] addr);
    vec_t r;
    r.en = e; r.fs = fs; r.rv = rv; r.ry = ry; r.fr = fr; r.fd = fd;
    r.ctl = ctl; r.line = line; r.addr = addr;
    return r;
  endfunction

  initial begin
    vec_t tbl [15];
    int   w, a0, n0, r0;
    logic gfd, gfl;

    // H=2, base address 0x100, stride 0x40, fetching unit driven by hand.
    tbl[0]  = v(1, 1, 0, 0, 0, 0, 7'b0000000, 0, 0);
    tbl[1]  = v(1, 0, 0, 0, 0, 1, 7'b0000010, 0, 0);
    tbl[2]  = v(1, 0, 0, 0, 0, 0, 7'b0000110, 0, 32'h100);
    tbl[3]  = v(0, 0, 0, 0, 1, 0, 7'b0000110, 0, 32'h100);
    tbl[4]  = v(1, 0, 0, 0, 1, 0, 7'b0000110, 0, 32'h100);
    tbl[5]  = v(1, 1, 0, 0, 0, 0, 7'b0000010, 0, 0);
    tbl[6]  = v(1, 0, 0, 0, 0, 1, 7'b0000010, 0, 0);
    tbl[7]  = v(1, 0, 1, 0, 0, 0, 7'b0000010, 0, 0);
    tbl[8]  = v(1, 0, 1, 0, 1, 0, 7'b0000110, 1, 32'h140);
    tbl[9]  = v(1, 0, 1, 0, 0, 1, 7'b0000010, 0, 0);
    tbl[10] = v(1, 0, 1, 0, 0, 0, 7'b1000010, 0, 0);
    tbl[11] = v(1, 0, 1, 1, 0, 0, 7'b0100010, 0, 0);
    tbl[12] = v(0, 0, 1, 1, 0, 0, 7'b0000010, 0, 0);
    tbl[13] = v(1, 0, 1, 1, 0, 0, 7'b1011010, 0, 0);
    tbl[14] = v(1, 0, 1, 0, 0, 0, 7'b0000000, 0, 0);

    #2;
    check("reset_ctl", {25'd0, tex_request_ready, bu_next_line, bu_flush, frame_done,
                        fetch_valid, busy, seq_err}, 32'd0);
    check("reset_payload", {8'd0, fetch_line_number, stall_cycles[11:0]}, 32'd0);
    check("reset_addr", fetch_line_addr, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    cfg_image_height = 12'd2;
    cfg_frame_addr   = 32'h100;
    cfg_line_stride  = 32'h40;
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; frame_start = tbl[i].fs;
      tex_request_valid = tbl[i].rv; tex_request_y = tbl[i].ry;
      t_ready = tbl[i].fr; t_done = tbl[i].fd;
      @(negedge clk);
      check($sformatf("row%0d_ctl", i),
            {25'd0, tex_request_ready, bu_next_line, bu_flush, frame_done,
             fetch_valid, busy, seq_err}, {25'd0, tbl[i].ctl});
      if (tbl[i].ctl[2]) begin
        check($sformatf("row%0d_line", i), {20'd0, fetch_line_number}, {20'd0, tbl[i].line});
        check($sformatf("row%0d_addr", i), fetch_line_addr, tbl[i].addr);
      end
      tick();
    end
    en = 1'b1; frame_start = 1'b0; tex_request_valid = 1'b0; t_ready = 1'b0; t_done = 1'b0;

    // Prefetch fills the 5-line ring and then stops.
    auto_fu = 1'b1; done_delay = 3;
    a0 = acc_cnt;
    start_frame(12'd8, 32'h1000_0000, 32'h800);
    repeat (60) tick();
    check("prefetch_count", acc_cnt - a0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("prefetch_line%0d", i), {20'd0, acc_line[(a0 + i) % 64]}, i);
      check($sformatf("prefetch_addr%0d", i), acc_addr[(a0 + i) % 64], 32'h1000_0000 + i * 32'h800);
    end
    check("prefetch_idle_valid", {31'd0, fetch_valid}, 32'd0);

    // Advance: y=0 needs no retire; y=1 retires line 0 and lets line 5 in.
    n0 = nl_cnt; r0 = ready_cnt;
    request(12'd0, 50, w, gfd, gfl);
    check("adv0_ready_pulses", ready_cnt - r0, 32'd1);
    check("adv0_next_line", nl_cnt - n0, 32'd0);
    n0 = nl_cnt; r0 = ready_cnt;
    request(12'd1, 50, w, gfd, gfl);
    repeat (12) tick();
    check("adv1_next_line", nl_cnt - n0, 32'd1);
    check("adv1_ready_pulses", ready_cnt - r0, 32'd1);
    check("adv1_fetch_count", acc_cnt - a0, 32'd6);
    check("adv1_fetch_line", {20'd0, acc_line[(a0 + 5) % 64]}, 32'd5);
    check("adv1_fetch_addr", acc_addr[(a0 + 5) % 64], 32'h1000_2800);

    // Bottom clamp: y=6 needs only lines 6 and 7, y=7 closes the frame.
    for (int y = 2; y <= 6; y++) request(12'(y), 200, w, gfd, gfl);
    check("clamp_all_lines_fetched", acc_cnt - a0, 32'd8);
    request(12'd7, 200, w, gfd, gfl);
    check("clamp_frame_done", {31'd0, gfd}, 32'd1);
    check("clamp_flush", {31'd0, gfl}, 32'd1);
    check("clamp_busy_drop", {31'd0, busy}, 32'd0);

    // Backward request once base has moved to 3.
    start_frame(12'd8, 32'h2000_0000, 32'h100);
    for (int y = 0; y <= 3; y++) request(12'(y), 200, w, gfd, gfl);
    n0 = nl_cnt;
    request(12'd2, 20, w, gfd, gfl);
    check("back_seq_err", {31'd0, seq_err}, 32'd1);
    check("back_no_retire", nl_cnt - n0, 32'd0);
    for (int y = 3; y <= 7; y++) request(12'(y), 200, w, gfd, gfl);
    tick();
    check("back_seq_err_sticky", {30'd0, seq_err, busy}, 32'd2);

    // en low in FETCH_REQ, then asynchronous reset in FETCH_WAIT.
    auto_fu = 1'b0; t_ready = 1'b0;
    start_frame(12'd8, 32'h3000_0000, 32'h10);
    check("restart_clears_seq_err", {31'd0, seq_err}, 32'd0);
    tick();
    check("en_req_valid", {31'd0, fetch_valid}, 32'd1);
    en = 1'b0; t_ready = 1'b1;
    repeat (3) tick();
    check("en_hold_ctl", {30'd0, fetch_valid, busy}, 32'd3);
    check("en_hold_line", {20'd0, fetch_line_number}, 32'd0);
    check("en_hold_addr", fetch_line_addr, 32'h3000_0000);
    en = 1'b1;
    tick();
    t_ready = 1'b0;
    check("wait_state", {30'd0, fetch_valid, busy}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("async_reset_ctl", {25'd0, tex_request_ready, bu_next_line, bu_flush, frame_done,
                              fetch_valid, busy, seq_err}, 32'd0);
    check("async_reset_addr", fetch_line_addr, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    repeat (3) tick();
    check("late_done_ignored", {30'd0, fetch_valid, busy}, 32'd0);

    // Stall counter: request y=0 right after the frame starts, slow fetches.
    auto_fu = 1'b1; done_delay = 10;
    start_frame(12'd8, 32'h4000_0000, 32'h800);
    request(12'd0, 500, w, gfd, gfl);
`ifdef DC_LFS_STALL_COUNTER_EN
    check("stall_cycles", {16'd0, stall_cycles}, w);
`else
    check("stall_cycles_tied", {16'd0, stall_cycles}, 32'd0);
`endif
    auto_fu = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
